// File: rtl/gpu_pkg.sv
// Shared GPU dispatch types: opcode encoding, instruction-word field layout, decoded instruction.
// Pure declarations; no timing or backpressure.
package gpu_pkg;

  typedef enum logic [2:0] {
    NOP  = 3'b000,
    SUB  = 3'b001,
    MUL  = 3'b010,
    ADD  = 3'b011,
    FADD = 3'b100,
    FSUB = 3'b101,
    INIT = 3'b110,
    END  = 3'b111
  } opcode_e;

  localparam int INSTR_W   = 32;
  localparam int TYPE_LSB  = 29;
  localparam int TYPE_W    = 3;
  localparam int DEST_LSB  = 24;
  localparam int RS1_LSB   = 19;
  localparam int RS2_LSB   = 14;
  localparam int REG_W     = 5;
  localparam int SHAMT_LSB = 8;
  localparam int SHAMT_W   = 6;

  typedef struct packed {
    opcode_e            op;
    logic [REG_W-1:0]   dest_reg;
    logic [REG_W-1:0]   regnum_1;
    logic [REG_W-1:0]   regnum_2;
    logic [SHAMT_W-1:0] shammt;
  } instr_t;

endpackage

// File: rtl/warp_dispatcher_if.sv
// Dispatcher-facing bus: instruction-memory request/response plus per-lane broadcast and completion.
// Fetch has no request backpressure; the dispatcher waits indefinitely for the response strobe.
interface warp_dispatcher_if #(
  parameter int NUM_THREADS = 4,
  parameter int PC_W        = 8
) ();

  logic                   imem_req_valid;
  logic [PC_W-1:0]        imem_addr;
  logic                   imem_resp_valid;
  logic [31:0]            imem_resp_data;

  logic [2:0]             type_instruction;
  logic [4:0]             regnum_1;
  logic [4:0]             regnum_2;
  logic [4:0]             dest_reg;
  logic [5:0]             shammt;
  logic [NUM_THREADS-1:0] is_active;
  logic [NUM_THREADS-1:0] thread_complete;

  modport master (
    output imem_req_valid, imem_addr,
    input  imem_resp_valid, imem_resp_data,
    output type_instruction, regnum_1, regnum_2, dest_reg, shammt, is_active,
    input  thread_complete
  );

  modport slave (
    input  imem_req_valid, imem_addr,
    output imem_resp_valid, imem_resp_data,
    input  type_instruction, regnum_1, regnum_2, dest_reg, shammt, is_active,
    output thread_complete
  );

endinterface

// File: rtl/instr_decode.sv
// Splits a 32-bit instruction word into its decoded fields; purely combinational, zero latency.
// No flow control.
module instr_decode
  import gpu_pkg::*;
(
  input  logic [INSTR_W-1:0] word,
  output instr_t             dec
);

  // Low byte carries no architectural meaning.
  logic unused_low;
  assign unused_low = ^word[SHAMT_LSB-1:0];

  always_comb begin
    dec.op       = opcode_e'(word[TYPE_LSB +: TYPE_W]);
    dec.dest_reg = word[DEST_LSB +: REG_W];
    dec.regnum_1 = word[RS1_LSB +: REG_W];
    dec.regnum_2 = word[RS2_LSB +: REG_W];
    dec.shammt   = word[SHAMT_LSB +: SHAMT_W];
  end

endmodule

// File: rtl/warp_dispatcher.sv
// Fetches a program from base_pc and broadcasts each decoded instruction to all active lanes until END, then drains.
// 3+ cycles per instruction (fetch, wait, issue); stalls unbounded on imem response, drain bounded by DRAIN_TIMEOUT.
module warp_dispatcher
  import gpu_pkg::*;
#(
  parameter int NUM_THREADS   = 4,
  parameter int PC_W          = 8,
  parameter int DRAIN_TIMEOUT = 15
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [PC_W-1:0]        base_pc,
  input  logic [NUM_THREADS-1:0] thread_mask,
  warp_dispatcher_if.master      bus,
  output logic                   busy,
  output logic                   done,
  output logic                   timeout_err,
  output logic [15:0]            instr_count
);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    WAIT_RESP,
    ISSUE,
    DRAIN,
    FINISH
  } state_e;

  localparam int CNT_W = (DRAIN_TIMEOUT > 1) ? $clog2(DRAIN_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DRAIN_TIMEOUT - 1);

  state_e                 state;
  state_e                 state_next;
  logic [PC_W-1:0]        pc;
  logic [NUM_THREADS-1:0] mask;
  logic [INSTR_W-1:0]     instr_q;
  logic [CNT_W-1:0]       drain_cnt;
  instr_t                 dec;
  logic                   all_complete;
  logic                   is_end;

  instr_decode u_decode (
    .word (instr_q),
    .dec  (dec)
  );

  assign all_complete = &bus.thread_complete;
  assign is_end       = (dec.op == END);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next           = state;
    bus.imem_req_valid   = 1'b0;
    bus.imem_addr        = '0;
    bus.type_instruction = NOP;
    bus.dest_reg         = '0;
    bus.regnum_1         = '0;
    bus.regnum_2         = '0;
    bus.shammt           = '0;
    bus.is_active        = '0;
    busy                 = (state != IDLE);
    done                 = 1'b0;

    if (state != IDLE && state != FINISH) bus.is_active = mask;

    case (state)
      IDLE: begin
        if (start) state_next = FETCH;
      end
      FETCH: begin
        bus.imem_req_valid = 1'b1;
        bus.imem_addr      = pc;
        state_next         = WAIT_RESP;
      end
      WAIT_RESP: begin
        if (bus.imem_resp_valid) state_next = ISSUE;
      end
      ISSUE: begin
        bus.type_instruction = dec.op;
        bus.dest_reg         = dec.dest_reg;
        bus.regnum_1         = dec.regnum_1;
        bus.regnum_2         = dec.regnum_2;
        bus.shammt           = dec.shammt;
        state_next           = is_end ? DRAIN : FETCH;
      end
      DRAIN: begin
        if (all_complete || drain_cnt == CNT_LAST) state_next = FINISH;
      end
      FINISH: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc          <= '0;
      mask        <= '0;
      instr_q     <= '0;
      drain_cnt   <= '0;
      instr_count <= '0;
      timeout_err <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            pc          <= base_pc;
            mask        <= thread_mask;
            instr_count <= '0;
            timeout_err <= 1'b0;
          end
        end
        WAIT_RESP: begin
          if (bus.imem_resp_valid) instr_q <= bus.imem_resp_data;
        end
        ISSUE: begin
          if (instr_count != 16'hFFFF) instr_count <= instr_count + 16'd1;
          if (!is_end) pc <= pc + PC_W'(1);
          drain_cnt <= '0;
        end
        DRAIN: begin
          // Completion wins over timeout when both land on the last drain cycle.
          if (!all_complete) begin
            if (drain_cnt == CNT_LAST) timeout_err <= 1'b1;
            else                       drain_cnt   <= drain_cnt + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_warp_dispatcher.sv
// Bench for warp_dispatcher: builds an expected per-cycle timeline from the program, delays and lane
// completion time, then replays it against the DUT cycle by cycle.
module tb_warp_dispatcher;

  localparam int NT = 4;
  localparam int PW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [PW-1:0] base_pc;
  logic [NT-1:0] thread_mask;
  logic          busy;
  logic          done;
  logic          timeout_err;
  logic [15:0]   instr_count;

  warp_dispatcher_if #(.NUM_THREADS(NT), .PC_W(PW)) bus ();

  warp_dispatcher #(.NUM_THREADS(NT), .PC_W(PW), .DRAIN_TIMEOUT(15)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .base_pc     (base_pc),
    .thread_mask (thread_mask),
    .bus         (bus),
    .busy        (busy),
    .done        (done),
    .timeout_err (timeout_err),
    .instr_count (instr_count)
  );

  always #5 clk = ~clk;

  // One entry per clock: expected outputs, plus the inputs the bench drives during that cycle.
  typedef struct {
    logic        req;
    logic [7:0]  addr;
    logic [23:0] fld;
    logic [3:0]  act;
    logic        bsy;
    logic        dn;
    logic        terr;
    logic [15:0] cnt;
    logic        st;
    logic        rv;
    logic [31:0] rd;
    logic [3:0]  tc;
  } cyc_t;

  cyc_t        tl[$];
  logic [31:0] mem [256];
  int          n_assert = 0;
  int          n_fail   = 0;

  function automatic cyc_t blank();
    cyc_t c;
    c.req = 1'b0; c.addr = '0; c.fld = '0; c.act = '0; c.bsy = 1'b0; c.dn = 1'b0;
    c.terr = 1'b0; c.cnt = '0; c.st = 1'b0; c.rv = 1'b0; c.rd = '0; c.tc = '0;
    return c;
  endfunction

  function automatic logic [23:0] fields(input logic [31:0] w);
    return {w[31:29], w[28:24], w[23:19], w[18:14], w[13:8]};
  endfunction

  task automatic chk(input string tag, input int k, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, k, obs, exp);
    end
  endtask

  task automatic check_cycle(input string tag, input int k, input cyc_t e);
    chk({tag, ".imem"}, k, 64'({bus.imem_req_valid, bus.imem_addr}), 64'({e.req, e.addr}));
    chk({tag, ".fields"}, k,
        64'({bus.type_instruction, bus.dest_reg, bus.regnum_1, bus.regnum_2, bus.shammt}), 64'(e.fld));
    chk({tag, ".status"}, k,
        64'({bus.is_active, busy, done, timeout_err, instr_count}),
        64'({e.act, e.bsy, e.dn, e.terr, e.cnt}));
  endtask

  // Timeline: per instruction FETCH, d wait cycles (response in the last), ISSUE; then drain, done, idle.
  // cdone = drain cycle index at which all lanes first report complete (>14 means never).
  task automatic build(input logic [7:0] base, input logic [3:0] mask, input int dmin, input int dmax,
                       input int cdone, input bit noise);
    cyc_t        c;
    logic [7:0]  pc;
    logic [15:0] cnt;
    logic [31:0] w;
    int          d;
    int          ndrain;
    bit          to;
    tl.delete();
    pc  = base;
    cnt = '0;
    for (int i = 0; i < 64; i++) begin
      w = mem[pc];
      c = blank(); c.req = 1'b1; c.addr = pc; c.act = mask; c.bsy = 1'b1; c.cnt = cnt;
      if (noise) begin
        c.rv = 1'($urandom_range(0, 1)); c.rd = $urandom; c.st = 1'($urandom_range(0, 1));
        c.tc = 4'($urandom_range(0, 15));
      end
      tl.push_back(c);
      d = $urandom_range(dmin, dmax);
      for (int j = 0; j < d; j++) begin
        c = blank(); c.act = mask; c.bsy = 1'b1; c.cnt = cnt;
        if (j == d - 1) begin c.rv = 1'b1; c.rd = w; end
        if (noise) c.st = 1'($urandom_range(0, 1));
        tl.push_back(c);
      end
      c = blank(); c.fld = fields(w); c.act = mask; c.bsy = 1'b1; c.cnt = cnt;
      if (noise) begin
        c.rv = 1'($urandom_range(0, 1)); c.rd = $urandom; c.st = 1'($urandom_range(0, 1));
        c.tc = 4'($urandom_range(0, 15));
      end
      tl.push_back(c);
      if (cnt != 16'hFFFF) cnt++;
      if (w[31:29] == 3'b111) break;
      pc = pc + 8'd1;
    end
    to     = (cdone > 14);
    ndrain = to ? 15 : cdone + 1;
    for (int j = 0; j < ndrain; j++) begin
      c = blank(); c.act = mask; c.bsy = 1'b1; c.cnt = cnt;
      c.tc = (j >= cdone) ? 4'hF : 4'($urandom_range(0, 14));
      if (noise) begin c.st = 1'($urandom_range(0, 1)); c.rv = 1'($urandom_range(0, 1)); end
      tl.push_back(c);
    end
    c = blank(); c.bsy = 1'b1; c.dn = 1'b1; c.terr = to; c.cnt = cnt;
    if (noise) c.st = 1'($urandom_range(0, 1));
    tl.push_back(c);
    c = blank(); c.terr = to; c.cnt = cnt;
    tl.push_back(c);
  endtask

  task automatic play(input string tag, input logic [7:0] base, input logic [3:0] mask);
    @(negedge clk);
    start = 1'b1; base_pc = base; thread_mask = mask;
    bus.imem_resp_valid = 1'b0; bus.thread_complete = '0;
    foreach (tl[k]) begin
      @(negedge clk);
      check_cycle(tag, k, tl[k]);
      start               = tl[k].st;
      base_pc             = 8'($urandom);
      thread_mask         = 4'($urandom);
      bus.imem_resp_valid = tl[k].rv;
      bus.imem_resp_data  = tl[k].rd;
      bus.thread_complete = tl[k].tc;
    end
    start = 1'b0;
  endtask

  initial begin
    cyc_t        e;
    logic [31:0] w;
    logic [7:0]  b;
    logic [3:0]  m;
    int          len;

    rst = 1'b1; start = 1'b0; base_pc = '0; thread_mask = '0;
    bus.imem_resp_valid = 1'b0; bus.imem_resp_data = '0; bus.thread_complete = '0;
    for (int i = 0; i < 256; i++) mem[i] = '0;
    repeat (2) @(negedge clk);
    check_cycle("reset", 0, blank());
    @(negedge clk);
    rst = 1'b0;

    // INIT, ADD d=3 r1=1 r2=2, END; junk in the ignored low byte.
    mem[8'h10] = {3'b110, 5'd7, 5'd0, 5'd0, 6'd0, 8'hAA};
    mem[8'h11] = {3'b011, 5'd3, 5'd1, 5'd2, 6'd0, 8'h00};
    mem[8'h12] = {3'b111, 5'd0, 5'd0, 5'd0, 6'd0, 8'h00};
    build(8'h10, 4'hF, 1, 1, 1, 1'b0);
    play("prog3", 8'h10, 4'hF);

    build(8'h10, 4'hF, 6, 6, 1, 1'b0);
    play("slow_resp", 8'h10, 4'hF);

    build(8'h10, 4'b0101, 1, 2, 0, 1'b0);
    play("mask0101", 8'h10, 4'b0101);

    build(8'h10, 4'hF, 1, 1, 99, 1'b0);
    play("timeout", 8'h10, 4'hF);

    mem[8'hFF] = {3'b001, 5'd4, 5'd5, 5'd6, 6'd33, 8'h00};
    mem[8'h00] = {3'b111, 5'd1, 5'd2, 5'd3, 6'd4, 8'h00};
    build(8'hFF, 4'hF, 1, 1, 0, 1'b0);
    play("pc_wrap", 8'hFF, 4'hF);

    // Reset while waiting for a fetch response; the late response must be ignored.
    mem[8'h40] = {3'b011, 5'd9, 5'd8, 5'd7, 6'd5, 8'h00};
    mem[8'h41] = {3'b111, 29'd0};
    @(negedge clk);
    start = 1'b1; base_pc = 8'h40; thread_mask = 4'hF;
    @(negedge clk);
    start = 1'b0;
    e = blank(); e.req = 1'b1; e.addr = 8'h40; e.act = 4'hF; e.bsy = 1'b1;
    check_cycle("rst_fetch", 0, e);
    @(negedge clk);
    e.req = 1'b0; e.addr = '0;
    check_cycle("rst_wait", 1, e);
    rst = 1'b1;
    #1;
    check_cycle("rst_async", 2, blank());
    @(negedge clk);
    rst = 1'b0;
    bus.imem_resp_valid = 1'b1; bus.imem_resp_data = mem[8'h40];
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check_cycle("rst_after", k, blank());
      bus.imem_resp_valid = 1'b0;
    end
    build(8'h40, 4'hF, 1, 3, 2, 1'b0);
    play("post_rst", 8'h40, 4'hF);

    // Random programs with spurious responses, completions and start pulses.
    for (int r = 0; r < 20; r++) begin
      b   = 8'($urandom);
      m   = 4'($urandom);
      len = $urandom_range(0, 6);
      for (int i = 0; i < len; i++) begin
        w = $urandom;
        w[31:29] = 3'($urandom_range(0, 6));
        mem[8'(b + 8'(i))] = w;
      end
      w = $urandom;
      w[31:29] = 3'b111;
      mem[8'(b + 8'(len))] = w;
      build(b, m, 1, 4, $urandom_range(0, 17), 1'b1);
      play("random", b, m);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
